// File: rtl/regbank_seq_if.sv
// Controller-side handshake between the issuing controller and the regbank sequencer.
// The controller drives the request fields; the sequencer returns status and the ALU result.
interface regbank_seq_if #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 9
);
    logic          start;
    logic [2:0]    op;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [AW-1:0] ad;
    logic [DW-1:0] imm;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] result;
    logic          carry;

    modport master (
        output start, op, a1, a2, ad, imm,
        input  busy, done, err, result, carry
    );

    modport slave (
        input  start, op, a1, a2, ad, imm,
        output busy, done, err, result, carry
    );
endinterface

// File: rtl/regbank_seq.sv
// Micro-op sequencer for a 10 x 9-bit register bank: read two sources, run the ALU,
// write the destination back, and report completion through start/busy/done/err.
module regbank_seq #(
    parameter int unsigned NREG = 10,
    parameter int unsigned DW   = 9,
    parameter int unsigned AW   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    regbank_seq_if.slave  ctl,
    output logic [AW-1:0] sr1,
    output logic [AW-1:0] sr2,
    input  logic [DW-1:0] dsr1,
    input  logic [DW-1:0] dsr2,
    output logic [AW-1:0] dr,
    output logic [DW-1:0] din,
    output logic          write
);
    localparam int unsigned SW = DW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_EXEC, S_WRITE, S_DONE, S_ERR
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
        OP_XOR = 3'd4, OP_MOV = 3'd5, OP_LDI = 3'd6, OP_RSV = 3'd7
    } op_t;

    state_t        state, state_nx;
    op_t           op_q, op_nx;
    logic [AW-1:0] ad_q, ad_nx;
    logic [DW-1:0] imm_q, imm_nx;
    logic [DW-1:0] opnd1, opnd1_nx;
    logic [DW-1:0] opnd2, opnd2_nx;
    logic [DW-1:0] result_nx;
    logic          carry_nx;
    logic [AW-1:0] sr1_nx, sr2_nx, dr_nx;
    logic          busy_nx, done_nx, err_nx, write_nx;

    logic          bad1_c, bad2_c, badd_c, illegal_c;
    logic [SW-1:0] sum_c, diff_c;

    // Request legality: only the addresses an opcode actually uses are range-checked
    always_comb begin
        bad1_c    = ctl.a1 >= AW'(NREG);
        bad2_c    = ctl.a2 >= AW'(NREG);
        badd_c    = ctl.ad >= AW'(NREG);
        illegal_c = 1'b1;
        case (op_t'(ctl.op))
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: illegal_c = bad1_c | bad2_c | badd_c;
            OP_MOV:                                illegal_c = bad1_c | badd_c;
            OP_LDI:                                illegal_c = badd_c;
            default:                               illegal_c = 1'b1;
        endcase
    end

    // Zero-extended arithmetic; the top bit is the carry out or the borrow
    assign sum_c  = SW'(opnd1) + SW'(opnd2);
    assign diff_c = SW'(opnd1) - SW'(opnd2);

    always_comb begin
        state_nx  = state;
        op_nx     = op_q;
        ad_nx     = ad_q;
        imm_nx    = imm_q;
        opnd1_nx  = opnd1;
        opnd2_nx  = opnd2;
        result_nx = ctl.result;
        carry_nx  = ctl.carry;
        sr1_nx    = sr1;
        sr2_nx    = sr2;
        dr_nx     = dr;

        case (state)
            S_IDLE: begin
                if (ctl.start) begin
                    op_nx  = op_t'(ctl.op);
                    ad_nx  = ctl.ad;
                    imm_nx = ctl.imm;
                    if (illegal_c) begin
                        state_nx = S_ERR;
                    end else begin
                        state_nx = S_READ;
                        sr1_nx   = ctl.a1;
                        sr2_nx   = ctl.a2;
                    end
                end
            end
            S_READ: begin
                opnd1_nx = dsr1;
                opnd2_nx = dsr2;
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                carry_nx = 1'b0;
                case (op_q)
                    OP_ADD: begin
                        result_nx = sum_c[DW-1:0];
                        carry_nx  = sum_c[DW];
                    end
                    OP_SUB: begin
                        result_nx = diff_c[DW-1:0];
                        carry_nx  = diff_c[DW];
                    end
                    OP_AND:  result_nx = opnd1 & opnd2;
                    OP_OR:   result_nx = opnd1 | opnd2;
                    OP_XOR:  result_nx = opnd1 ^ opnd2;
                    OP_MOV:  result_nx = opnd1;
                    OP_LDI:  result_nx = imm_q;
                    default: result_nx = ctl.result;
                endcase
                dr_nx    = ad_q;
                state_nx = S_WRITE;
            end
            S_WRITE: state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        // Status outputs are decoded from the next state so they register in step with it
        busy_nx  = (state_nx == S_READ) || (state_nx == S_EXEC) || (state_nx == S_WRITE);
        write_nx = (state_nx == S_WRITE);
        done_nx  = (state_nx == S_DONE) || (state_nx == S_ERR);
        err_nx   = (state_nx == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= OP_ADD;
            ad_q       <= '0;
            imm_q      <= '0;
            opnd1      <= '0;
            opnd2      <= '0;
            ctl.result <= '0;
            ctl.carry  <= 1'b0;
            ctl.busy   <= 1'b0;
            ctl.done   <= 1'b0;
            ctl.err    <= 1'b0;
            sr1        <= '0;
            sr2        <= '0;
            dr         <= '0;
            write      <= 1'b0;
        end else begin
            state      <= state_nx;
            op_q       <= op_nx;
            ad_q       <= ad_nx;
            imm_q      <= imm_nx;
            opnd1      <= opnd1_nx;
            opnd2      <= opnd2_nx;
            ctl.result <= result_nx;
            ctl.carry  <= carry_nx;
            ctl.busy   <= busy_nx;
            ctl.done   <= done_nx;
            ctl.err    <= err_nx;
            sr1        <= sr1_nx;
            sr2        <= sr2_nx;
            dr         <= dr_nx;
            write      <= write_nx;
        end
    end

    // Write data is the registered result itself
    assign din = ctl.result;

endmodule

// File: tb/tb_regbank_seq.sv
// Scoreboard bench for regbank_seq: directed ops push expected done/write events,
// a negedge monitor pops and compares them, including cycle-accurate latency.
module tb_regbank_seq;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 9;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           XOR_ = 3'd4, MOV = 3'd5, LDI = 3'd6, RSV = 3'd7;

    typedef struct {
        bit          e;
        logic [8:0]  r;
        bit          c;
        int          cy;
    } dexp_t;

    typedef struct {
        logic [3:0]  d;
        logic [8:0]  v;
        int          cy;
    } wexp_t;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] sr1, sr2, dr;
    logic [DW-1:0] dsr1, dsr2, din;
    logic          write;
    logic [DW-1:0] bank [16];
    int            cyc;
    int            tests;
    int            fails;
    dexp_t         dq[$];
    wexp_t         wq[$];

    regbank_seq_if #(.AW(AW), .DW(DW)) ifc ();

    regbank_seq #(.NREG(10), .DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (ifc),
        .sr1   (sr1),
        .sr2   (sr2),
        .dsr1  (dsr1),
        .dsr2  (dsr2),
        .dr    (dr),
        .din   (din),
        .write (write)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register bank: combinational reads, synchronous write
    always @(posedge clk) if (write) bank[dr] <= din;
    assign dsr1 = bank[sr1];
    assign dsr2 = bank[sr2];

    function automatic void chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        dexp_t x;
        wexp_t w;
        if (rst_n) begin
            if (write) begin
                if (wq.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    w = wq.pop_front();
                    chk("write_dr", dr, w.d);
                    chk("write_din", din, w.v);
                    chk("write_cycle", cyc, w.cy);
                end
            end
            if (ifc.done) begin
                if (dq.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    x = dq.pop_front();
                    chk("done_err", ifc.err, x.e);
                    chk("done_result", ifc.result, x.r);
                    chk("done_carry", ifc.carry, x.c);
                    chk("done_cycle", cyc, x.cy);
                    chk("busy_at_done", ifc.busy, 0);
                end
            end
        end
    end

    // Issue one op with its hand-computed outcome; hold keeps start high through DONE
    task automatic issue(input logic [2:0] o, input logic [3:0] x1, input logic [3:0] x2,
                         input logic [3:0] xd, input logic [8:0] im,
                         input bit e, input logic [8:0] r, input bit c, input bit hold);
        int  ic;
        bit  got;
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.op    = o;
        ifc.a1    = x1;
        ifc.a2    = x2;
        ifc.ad    = xd;
        ifc.imm   = im;
        ic = cyc + 1;
        dq.push_back('{e, r, c, e ? ic : ic + 3});
        if (!e) wq.push_back('{xd, r, ic + 2});
        @(negedge clk);
        if (hold) begin
            ifc.op  = LDI;
            ifc.ad  = 4'd7;
            ifc.imm = 9'd1;
        end else begin
            ifc.start = 1'b0;
        end
        got = 0;
        for (int n = 0; n < 8; n++) begin
            if (ifc.done) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            chk("done_timeout", 0, 1);
            dq.delete();
            wq.delete();
        end
        if (hold) begin
            @(negedge clk);
            ifc.start = 1'b0;
        end
    endtask

    initial begin
        clk = 1'b0;
        cyc = 0;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        ifc.start = 1'b0;
        ifc.op = 3'd0;
        ifc.a1 = '0;
        ifc.a2 = '0;
        ifc.ad = '0;
        ifc.imm = '0;
        for (int i = 0; i < 16; i++) bank[i] = '0;

        #12;
        chk("rst_busy", ifc.busy, 0);
        chk("rst_done", ifc.done, 0);
        chk("rst_err", ifc.err, 0);
        chk("rst_write", write, 0);
        chk("rst_carry", ifc.carry, 0);
        chk("rst_result", ifc.result, 0);
        chk("rst_sr1", sr1, 0);
        chk("rst_dr", dr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD with carry out: 100 + 450 = 550 -> 38, carry 1
        issue(LDI, 4'd0, 4'd0, 4'd2, 9'd100, 0, 9'd100, 0, 0);
        issue(LDI, 4'd0, 4'd0, 4'd3, 9'd450, 0, 9'd450, 0, 0);
        issue(ADD, 4'd2, 4'd3, 4'd5, 9'd0,   0, 9'd38,  1, 0);
        chk("bank_r5_add", bank[5], 38);

        // Illegal requests leave result/carry and the bank untouched
        issue(ADD, 4'd10, 4'd3, 4'd5, 9'd0,   1, 9'd38, 1, 0);
        issue(RSV, 4'd1,  4'd2, 4'd3, 9'd0,   1, 9'd38, 1, 0);
        issue(LDI, 4'd0,  4'd0, 4'd15, 9'd99, 1, 9'd38, 1, 0);
        issue(ADD, 4'd2,  4'd3, 4'd10, 9'd0,  1, 9'd38, 1, 0);
        chk("bank_r5_after_err", bank[5], 38);

        // SUB with and without borrow
        issue(LDI, 4'd0, 4'd0, 4'd1, 9'd5, 0, 9'd5, 0, 0);
        issue(LDI, 4'd0, 4'd0, 4'd4, 9'd7, 0, 9'd7, 0, 0);
        issue(SUB, 4'd1, 4'd4, 4'd6, 9'd0, 0, 9'd510, 1, 0);
        issue(SUB, 4'd4, 4'd1, 4'd6, 9'd0, 0, 9'd2,   0, 0);
        chk("bank_r6_sub", bank[6], 2);

        // Logic ops; MOV ignores an out-of-range a2; source equal to destination
        issue(LDI,  4'd0, 4'd0, 4'd2, 9'h1F0, 0, 9'h1F0, 0, 0);
        issue(LDI,  4'd0, 4'd0, 4'd3, 9'h0FF, 0, 9'h0FF, 0, 0);
        issue(AND_, 4'd2, 4'd3, 4'd7, 9'd0,   0, 9'h0F0, 0, 0);
        issue(OR_,  4'd2, 4'd3, 4'd8, 9'd0,   0, 9'h1FF, 0, 0);
        issue(XOR_, 4'd2, 4'd3, 4'd0, 9'd0,   0, 9'h10F, 0, 0);
        issue(MOV,  4'd3, 4'd15, 4'd9, 9'd0,  0, 9'h0FF, 0, 0);
        chk("bank_r9_mov", bank[9], 9'h0FF);
        issue(ADD,  4'd2, 4'd2, 4'd2, 9'd0,   0, 9'h1E0, 1, 0);
        chk("bank_r2_self", bank[2], 9'h1E0);

        // start held through READ..DONE must be ignored
        issue(LDI, 4'd0, 4'd0, 4'd1, 9'd300, 0, 9'd300, 0, 1);
        repeat (6) @(negedge clk);
        chk("bank_r7_not_written", bank[7], 9'h0F0);
        chk("idle_after_hold", ifc.busy, 0);

        // Reset during EXEC aborts with no write and no done
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.op    = LDI;
        ifc.ad    = 4'd5;
        ifc.imm   = 9'd77;
        @(negedge clk);
        ifc.start = 1'b0;
        @(negedge clk);
        chk("busy_in_exec", ifc.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", ifc.busy, 0);
        chk("abort_write", write, 0);
        chk("abort_done", ifc.done, 0);
        chk("abort_result", ifc.result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("bank_r5_after_abort", bank[5], 38);
        issue(LDI, 4'd0, 4'd0, 4'd5, 9'd77, 0, 9'd77, 0, 0);
        chk("bank_r5_after_ldi", bank[5], 77);

        repeat (3) @(negedge clk);
        chk("pending_done", dq.size(), 0);
        chk("pending_write", wq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regbank_seq.md
Name: regbank_seq

Overview:
Micro-op sequencer for the 10 x 9-bit register bank (two combinational read ports sr1/sr2, one synchronous write port dr/din/write). Accepts one operation per start pulse and drives the bank's read addresses. Computes an ALU result from the read data and writes it back to the destination register. Handshakes with the issuing controller through start/busy/done/err.

Parameters:
NREG, 10, number of implemented registers; any address >= NREG is illegal
DW, 9, data width; must match the bank
AW, 4, register address width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  issue request; sampled only in IDLE
op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV, 6 LDI, 7 reserved
a1  in  AW  source register 1 address
a2  in  AW  source register 2 address
ad  in  AW  destination register address
imm  in  DW  immediate value for LDI
busy  out  1  high while an operation is in flight
done  out  1  one-cycle completion pulse
err  out  1  valid with done; 1 = operation rejected, no write
result  out  DW  last computed result; holds until the next successful operation
carry  out  1  carry/borrow of the last operation
sr1  out  AW  bank read address 1
sr2  out  AW  bank read address 2
dsr1  in  DW  bank read data 1
dsr2  in  DW  bank read data 2
dr  out  AW  bank write address
din  out  DW  bank write data; equals result
write  out  1  bank write enable

Behaviour:
- Reset (async, immediate): state IDLE. busy, done, err, write, carry = 0. result, sr1, sr2, dr = 0.
- States: IDLE, READ, EXEC, WRITE, DONE, ERR.
- IDLE: on start=1, latch op/a1/a2/ad/imm.
  - Illegal request -> ERR. A request is illegal if op=7, or any used address >= NREG. ADD..XOR use a1, a2, ad; MOV uses a1, ad; LDI uses ad.
  - Otherwise -> READ.
- READ (busy=1): sr1/sr2 drive the latched a1/a2. dsr1/dsr2 captured into operand registers at the end of the cycle.
- EXEC (busy=1): compute and register result and carry.
  - ADD: 10-bit sum; result = sum[8:0]; carry = sum[9].
  - SUB: result = (dsr1 - dsr2) mod 512; carry = 1 if dsr1 < dsr2 (borrow).
  - AND, OR, XOR: bitwise; carry = 0.
  - MOV: result = dsr1; carry = 0.
  - LDI: result = imm; carry = 0.
- WRITE (busy=1): write=1 for exactly this cycle; dr = latched ad; din = result. The bank updates at the end of the cycle.
- DONE: busy=0, done=1, err=0 for one cycle -> IDLE.
- ERR: busy=0, done=1, err=1 for one cycle -> IDLE. No write; result and carry unchanged.
- Latency: start sampled at edge 0. write is high in cycle 3 and done in cycle 4. For an illegal request, done+err is in cycle 1.
- start outside IDLE (including DONE and ERR) is ignored; there is no queuing.
- Back-to-back: the next start is accepted on the cycle after done.
- sr1, sr2, dr hold their last latched values while idle. write is never high outside WRITE.
- Reset mid-operation: write and busy drop immediately and no done is produced. A write already committed at a prior edge stands; bank contents are not reset.
- A source register equal to the destination register is legal. The read happens in READ, before the write.

Test Plan:
- LDI ad=2 imm=100; LDI ad=3 imm=450; ADD a1=2 a2=3 ad=5 -> write in cycle 3 with dr=5 din=38, carry=1. done in cycle 4; reading r5 gives 38.
- LDI r1=5, r4=7; SUB a1=1 a2=4 ad=6 -> result=510, carry=1. SUB a1=4 a2=1 -> result=2, carry=0.
- r2=0x1F0, r3=0x0FF: AND/OR/XOR -> 0x0F0/0x1FF/0x10F, carry=0 each. MOV a1=3 ad=9 -> r9=0x0FF.
- ADD a1=10, or op=7, or LDI ad=15 -> done=err=1 in cycle 1; write never asserted; bank and result unchanged.
- start pulsed again in READ/EXEC/WRITE/DONE -> ignored; exactly one write and one done per accepted start.
- rst_n low during EXEC -> busy, write, done all 0 at once. Destination keeps its old value; a new LDI after reset works normally.
